// File: rtl/afifo_rd_stream_ctrl.sv
// Read-side drain controller: FIFO read issue with latency compensation, 4-entry skid buffer, burst-framed stream.
// Optional sequence checker is compiled in when the macro AFIFO_RD_CHECK_EN is defined.
module afifo_rd_stream_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int OUTPUT_REG = 0,
    parameter int BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [31:0]           words_out,
    output logic                  chk_err,
    output logic [7:0]            err_cnt
);
    localparam int RD_LAT = 1 + OUTPUT_REG;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic [DATA_WIDTH-1:0] r_buf [4];
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [2:0]            r_cnt;
    logic [RD_LAT-1:0]     r_inflight;
    logic [BEAT_W-1:0]     r_beat;
    logic [31:0]           r_words_out;
    logic [2:0]            w_inflight_n;
    logic                  w_push;
    logic                  w_pop;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    always_comb begin
        w_inflight_n = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight_n = w_inflight_n + 3'(r_inflight[i]);
        end
    end

    // Counting reads still in flight against free skid slots makes overflow impossible.
    assign fifo_rd_en = enable & ~fifo_rd_empty & ~tb_rst &
                        (({1'b0, r_cnt} + {1'b0, w_inflight_n}) < 4'd4);

    assign w_push    = r_inflight[RD_LAT-1];
    assign w_pop     = m_valid & m_ready;
    assign m_valid   = (r_cnt != 3'd0);
    assign m_data    = r_buf[r_rd_ptr];
    assign m_last    = m_valid & (r_beat == LAST_BEAT);
    assign words_out = r_words_out;

    // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            // NOTE: the skid storage is reset as well because m_data is read straight out of it.
            for (int i = 0; i < 4; i++) begin
                r_buf[i] <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_inflight  <= '0;
            r_beat      <= '0;
            r_words_out <= '0;
        end else begin
            r_inflight <= RD_LAT'({r_inflight, fifo_rd_en});
            if (w_push) begin
                r_buf[r_wr_ptr] <= fifo_rd_data;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 2'd1;
                r_beat      <= (r_beat == LAST_BEAT) ? '0 : r_beat + BEAT_W'(1);
                r_words_out <= r_words_out + 32'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef AFIFO_RD_CHECK_EN
    logic [DATA_WIDTH-1:0] r_exp;
    logic                  r_chk_err;
    logic [7:0]            r_err_cnt;
    logic                  w_mismatch;

    assign w_mismatch = w_pop & (m_data != r_exp);

    // Expected value tracks accepted beats, independent of whether they matched.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_exp     <= '1;
            r_chk_err <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_chk_err <= w_mismatch;
            if (w_pop) begin
                r_exp <= r_exp - DATA_WIDTH'(1);
            end
            if (w_mismatch && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign chk_err = r_chk_err;
    assign err_cnt = r_err_cnt;
`else
    assign chk_err = 1'b0;
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_afifo_rd_stream_ctrl.sv
// Self-checking bench for afifo_rd_stream_ctrl: FIFO behavioural model, queue scoreboard and directed/random steps.
// Checker expectations follow AFIFO_RD_CHECK_EN when it is defined for the build.
module tb_afifo_rd_stream_ctrl;
    localparam int DW         = 16;
    localparam int OUTPUT_REG = 1;
    localparam int RD_LAT     = 1 + OUTPUT_REG;
    localparam int BL         = 16;
`ifdef AFIFO_RD_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          tb_rst;
    logic          enable;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_empty;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic [31:0]   words_out;
    logic          chk_err;
    logic [7:0]    err_cnt;

    afifo_rd_stream_ctrl #(.DATA_WIDTH(DW), .OUTPUT_REG(OUTPUT_REG), .BURST_LEN(BL)) dut (
        .clk(clk), .tb_rst(tb_rst), .enable(enable),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .words_out(words_out), .chk_err(chk_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // FIFO model: words leave in push order, read data appears RD_LAT cycles after the strobe.
    logic [DW-1:0] fifo_mem [1024];
    int            fw = 0;
    int            fr = 0;
    logic [DW-1:0] pipe0 = '0;
    logic [DW-1:0] pipe1 = '0;
    logic [DW-1:0] sb[$];

    always @(posedge clk) begin
        if (tb_rst) fr <= fw;
        else if (fifo_rd_en) begin
            pipe0 <= fifo_mem[fr % 1024];
            fr    <= fr + 1;
        end
        pipe1 <= pipe0;
    end
    assign fifo_rd_empty = (fw == fr);
    assign fifo_rd_data  = (OUTPUT_REG != 0) ? pipe1 : pipe0;

    task automatic push(input logic [DW-1:0] w);
        fifo_mem[fw % 1024] = w;
        fw = fw + 1;
        sb.push_back(w);
    endtask

    // Stream monitor: in-order data, burst framing, beat count, checker pulses.
    int            n_hs = 0;
    int            n_rd = 0;
    int            n_pulse = 0;
    int            n_last_hs = 0;
    int            m_err = 0;
    bit            pend = 1'b0;
    logic [DW-1:0] exp_seq = '1;

    always @(negedge clk) begin
        if (tb_rst) begin
            sb.delete();
            n_hs = 0; n_last_hs = 0; m_err = 0; pend = 1'b0; exp_seq = '1;
        end else begin
            if (fifo_rd_en) n_rd++;
            if (chk_err) n_pulse++;
            chk("chk_err", 64'(chk_err), CHK_EN ? 64'(pend) : 64'd0);
            chk("err_cnt", 64'(err_cnt), CHK_EN ? 64'(m_err) : 64'd0);
            chk("words_out", 64'(words_out), 64'(n_hs));
            pend = 1'b0;
            if (m_valid) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    chk("m_data", 64'(m_data), 64'(sb[0]));
                    chk("m_last", 64'(m_last), 64'((n_hs % BL) == BL - 1));
                    if (m_ready) begin
                        pend = (sb[0] != exp_seq);
                        if (pend && m_err != 255) m_err++;
                        if (m_last) n_last_hs++;
                        exp_seq = exp_seq - 1'b1;
                        n_hs++;
                        void'(sb.pop_front());
                    end
                end
            end else begin
                chk("m_last_idle", 64'(m_last), 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((sb.size() != 0 || m_valid) && k < 2000) begin
            step();
            k++;
        end
        chk(tag, 64'(sb.size() == 0 && !m_valid), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] seq;
        int n0, r0, h0, k;
        tb_rst = 1'b1; enable = 1'b0; m_ready = 1'b0; seq = '1;
        #2;
        chk("reset_outputs", 64'({fifo_rd_en, m_valid, m_last, m_data, words_out, chk_err, err_cnt}), 64'd0);
        repeat (3) step();
        tb_rst = 1'b0;

        // Single word: strobe the same cycle empty falls, m_valid RD_LAT+1 cycles later.
        step();
        enable = 1'b1; m_ready = 1'b1; r0 = n_rd;
        push(seq); seq = seq - 1'b1;
        #1 chk("single_rd_en", 64'(fifo_rd_en), 64'd1);
        for (int i = 0; i < RD_LAT; i++) begin
            step();
            chk("single_wait_valid", 64'(m_valid), 64'd0);
        end
        step();
        chk("single_valid", 64'(m_valid), 64'd1);
        chk("single_data", 64'(m_data), 64'hFFFF);
        step();
        chk("single_words_out", 64'(words_out), 64'd1);
        chk("single_rd_pulses", 64'(n_rd - r0), 64'd1);

        // Streaming 256 words at one beat per cycle.
        for (int i = 0; i < 256; i++) begin
            push(seq); seq = seq - 1'b1;
        end
        k = 0;
        while (!m_valid && k < 20) begin step(); k++; end
        chk("stream_start", 64'(m_valid), 64'd1);
        n0 = n_hs;
        repeat (256) step();
        chk("stream_beats", 64'(n_hs - n0), 64'd256);
        chk("stream_words_out", 64'(words_out), 64'd257);
        chk("stream_err_cnt", 64'(err_cnt), 64'd0);

        // Backpressure: only four reads while the consumer stalls, resume after first pop.
        m_ready = 1'b0;
        step();
        r0 = n_rd;
        for (int i = 0; i < 10; i++) begin push(seq); seq = seq - 1'b1; end
        repeat (20) step();
        chk("bp_rd_pulses", 64'(n_rd - r0), 64'd4);
        m_ready = 1'b1;
        #1 chk("bp_full_no_rd", 64'(fifo_rd_en), 64'd0);
        step();
        chk("bp_resume", 64'(fifo_rd_en), 64'd1);
        drain("bp_drain");

        // Enable drop with two reads in flight.
        enable = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin push(seq); seq = seq - 1'b1; end
        h0 = n_hs; r0 = n_rd;
        enable = 1'b1;
        step(); step();
        enable = 1'b0;
        repeat (10) step();
        chk("endrop_rd_pulses", 64'(n_rd - r0), 64'd2);
        chk("endrop_delivered", 64'(n_hs - h0), 64'd2);
        enable = 1'b1;
        drain("endrop_drain");

        // Randomised ready/enable/arrival traffic.
        for (int c = 0; c < 400; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            enable  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
                    push(seq); seq = seq - 1'b1;
                end
            end
            step();
        end
        m_ready = 1'b1; enable = 1'b1;
        drain("random_drain");
        chk("random_err_cnt", 64'(err_cnt), 64'd0);

        // Corrupted word at the fourth position of a batch.
        n0 = n_pulse;
        for (int i = 0; i < 8; i++) begin
            push((i == 3) ? 16'h1234 : seq);
            seq = seq - 1'b1;
        end
        drain("inject_drain");
        step();
        chk("inject_pulses", 64'(n_pulse - n0), CHK_EN ? 64'd1 : 64'd0);
        chk("inject_err_cnt", 64'(err_cnt), CHK_EN ? 64'd1 : 64'd0);

        // Asynchronous reset while beat 7 is presented.
        for (int i = 0; i < 30; i++) begin push(seq); seq = seq - 1'b1; end
        k = 0;
        while (!(m_valid && (n_hs % BL) == 7) && k < 200) begin step(); k++; end
        chk("rst_reach_beat7", 64'(m_valid && (n_hs % BL) == 7), 64'd1);
        #2 tb_rst = 1'b1;
        #1 chk("rst_mid_outputs", 64'({fifo_rd_en, m_valid, m_last, m_data, words_out, chk_err, err_cnt}), 64'd0);
        step(); step();
        tb_rst = 1'b0;
        seq = '1;
        step();
        for (int i = 0; i < 20; i++) begin push(seq); seq = seq - 1'b1; end
        drain("rst_drain");
        step();
        chk("rst_words_out", 64'(words_out), 64'd20);
        chk("rst_last_count", 64'(n_last_hs), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/afifo_rd_stream_ctrl.md
# afifo_rd_stream_ctrl

Read-side drain controller for the 256-in/16-out asynchronous FIFO. It issues `fifo_rd_en` against the FIFO's empty flag and compensates for the FIFO read latency. Returned words land in a 4-entry skid buffer, which is presented downstream as a valid/ready stream with burst framing. It is the reader counterpart to the FIFO write path and sits between the FIFO read port and the downstream 16-bit consumer.

## Interface
- `DATA_WIDTH`, 16: FIFO read data width, equal to the stream width.
- `OUTPUT_REG`, 0: 1 when the FIFO output register is enabled. FIFO read latency is `RD_LAT = 1 + OUTPUT_REG`.
- `BURST_LEN`, 16: beats per burst. Must be ≥1. Drives `m_last`.
- `clk` input 1: single clock, shared with the FIFO `rd_clk`.
- `tb_rst` input 1: reset, asynchronous, active-high.
- `enable` input 1: drain enable.
- `fifo_rd_en` output 1: FIFO read strobe.
- `fifo_rd_data` input DATA_WIDTH: FIFO read data.
- `fifo_rd_empty` input 1: FIFO empty flag.
- `m_valid` output 1: stream data valid.
- `m_data` output DATA_WIDTH: stream data.
- `m_last` output 1: last beat of the current burst.
- `m_ready` input 1: downstream accept.
- `words_out` output 32: accepted-beat counter. Wraps at 2^32.
- `chk_err` output 1: sequence-check mismatch pulse. See Configuration.
- `err_cnt` output 8: saturating mismatch count. See Configuration.

## Operation
- **Reset values:** every output resets to 0. This includes `m_data`, `words_out`, `err_cnt`, the skid pointers and count, the in-flight shift register and the beat counter.
- **Read issue:** `fifo_rd_en = enable & ~fifo_rd_empty & (cnt + inflight < 4)`.
  - `cnt` is the skid occupancy, 0..4, 3 bits.
  - `inflight` is the number of set bits in an RD_LAT-deep shift register that carries `fifo_rd_en`.
  - This combinational term guarantees the skid buffer never overflows.
- **Capture:** when the in-flight shift register's tail bit is 1, `fifo_rd_data` is written at `wr_ptr` (2-bit, wraps 3→0).
- **Output:**
  - `m_valid = (cnt != 0)`.
  - `m_data = buf[rd_ptr]`.
  - A handshake is `m_valid & m_ready`. It advances `rd_ptr` (wrap 3→0).
- **Occupancy update:**
  - Push only: `cnt+1`.
  - Pop only: `cnt-1`.
  - Push and pop in the same cycle: `cnt` is unchanged and both pointers advance.
- **Burst counter:**
  - `beat` runs 0..BURST_LEN-1 and advances on each handshake, wrapping to 0.
  - `m_last = m_valid & (beat == BURST_LEN-1)`.
  - With `BURST_LEN = 1`, `m_last` is high on every valid beat.
- **`words_out`:** +1 per handshake.
- **`enable` deassert:** stops new reads only. In-flight words are still captured and buffered words still drain. `beat` holds its value.
- **`tb_rst` mid-operation:** clears all state immediately, including in-flight reads. The FIFO shares `tb_rst`, so lost reads are acceptable.
- **Stream rule:** `m_data` and `m_last` stay stable while `m_valid & ~m_ready`.

## Timing
- `fifo_rd_en` high in cycle N → `fifo_rd_data` sampled at the end of cycle N+RD_LAT → `m_valid` high in cycle N+RD_LAT+1.
- First-word latency from `fifo_rd_empty` falling, with `enable=1`: `fifo_rd_en` rises the same cycle and `m_valid` rises RD_LAT+1 cycles later.
- With `m_ready` held at 1 and the FIFO non-empty: sustained 1 beat/cycle for both RD_LAT=1 and RD_LAT=2.
- With `m_ready=0`:
  - `fifo_rd_en` stops once `cnt + inflight` reaches 4.
  - `fifo_rd_en` resumes the cycle after the first pop.
- `fifo_rd_empty` is sampled combinationally. The FIFO guarantees that data read while `~empty` is valid.

## Configuration
- **Macro:** `AFIFO_RD_CHECK_EN`.
- **When defined, a sequence checker is compiled in:**
  - The expected value starts at `{DATA_WIDTH{1'b1}}` and decrements by 1 on each handshake.
  - On a handshake with `m_data` ≠ expected, `chk_err` pulses high for one cycle, in the cycle after the handshake.
  - Each mismatch increments `err_cnt`, which saturates at 255.
  - The expected value follows the accepted sequence, not the data; it decrements whether or not the beat matched.
- **When undefined:** `chk_err` and `err_cnt` are tied to 0 and no checker logic is generated.

## Test plan
- **Single word:** reset, FIFO holds one word 16'hFFFF, `enable=1`, `m_ready=1`, OUTPUT_REG=0 → one `fifo_rd_en` pulse, then `m_valid` 2 cycles later with `m_data=16'hFFFF`; `words_out=1`.
- **Streaming:** 256 words in the FIFO, `m_ready=1`, OUTPUT_REG=1 → 256 consecutive beats at 1/cycle; `m_last` on beats 15, 31, …, 255; `words_out=256`; with the macro defined, `err_cnt=0`.
- **Backpressure:** `m_ready=0` for 20 cycles → exactly 4 `fifo_rd_en` pulses; `m_data` holds; after `m_ready=1` the order is preserved with no loss.
- **Enable drop:** `enable` falls while 2 reads are in flight (OUTPUT_REG=1) → no further `fifo_rd_en`; both in-flight words are delivered.
- **Checker:** inject a corrupted word 16'h1234 at beat 3, macro defined → one `chk_err` pulse and `err_cnt=1`; subsequent correct beats raise no error.
- **Reset mid-burst:** assert `tb_rst` at beat 7 → all outputs reset to 0 asynchronously; after release, `beat` restarts at 0.
